// File: rtl/seg7_scan_if.sv
// Load channel and scan outputs of the seven-segment scan controller.
// The controller takes the slave view; the load source takes the master view.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 8
);
    logic                      ld_valid;
    logic                      ld_ready;
    logic [4*NUM_DIGITS-1:0]   ld_value;
    logic [NUM_DIGITS-1:0]     ld_dp;
    logic                      lz_en;
    logic [3:0]                digit_nib;
    logic                      dp_n;
    logic [NUM_DIGITS-1:0]     an_n;
    logic                      frame_start;

    modport master (
        output ld_valid, ld_value, ld_dp, lz_en,
        input  ld_ready, digit_nib, dp_n, an_n, frame_start
    );

    modport slave (
        input  ld_valid, ld_value, ld_dp, lz_en,
        output ld_ready, digit_nib, dp_n, an_n, frame_start
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits: one digit per
// slot, anti-ghost blanking, leading-zero suppression, frame-aligned value updates.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV        = 1000,
    parameter int BLANK      = 16
) (
    input  logic       clk,
    input  logic       rst,
    seg7_scan_if.slave bus
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  run_q;
    logic [VAL_W-1:0]      act_val_q, act_val_d, pend_val_q;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q;
    logic                  pend_full_q, pend_full_d;
    logic                  ld_ready, xfer, at_end, commit;
    logic [3:0]            digit_nib_q, digit_nib_d;
    logic                  dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic                  frame_start_q, frame_start_d;
    logic                  blank, supp;
    logic [3:0]            nib_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] hi_zero;

    assign ld_ready = ~pend_full_q & ~rst;
    assign xfer     = bus.ld_valid & ld_ready;
    assign at_end   = run_q && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    assign commit   = at_end & pend_full_q;

    // run_q holds the position at slot 0 / cycle 0 for the first edge after reset,
    // so the first cycle out of reset is the start of a frame.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (run_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign act_val_d   = commit ? pend_val_q : act_val_q;
    assign act_dp_d    = commit ? pend_dp_q  : act_dp_q;
    assign pend_full_d = xfer ? 1'b1 : (commit ? 1'b0 : pend_full_q);

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
        assign nib_d[gi]   = act_val_d[4*gi +: 4];
        assign hi_zero[gi] = ((act_val_d >> (4*gi)) == '0);
    end

    if (BLANK > 0) begin : g_blank
        assign blank = (cnt_d < CNT_W'(BLANK));
    end else begin : g_noblank
        assign blank = 1'b0;
    end

    // Outputs are computed from the next position and value so the registered
    // copies line up with the cycle they describe.
    always_comb begin
        supp          = bus.lz_en && (idx_d != '0) && hi_zero[idx_d] && !act_dp_d[idx_d];
        digit_nib_d   = nib_d[idx_d];
        dp_n_d        = ~act_dp_d[idx_d];
        frame_start_d = (cnt_d == '0) && (idx_d == '0);
        an_n_d        = '1;
        if (!(blank || supp)) begin
            an_n_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            run_q         <= 1'b0;
            act_val_q     <= '0;
            act_dp_q      <= '0;
            pend_val_q    <= '0;
            pend_dp_q     <= '0;
            pend_full_q   <= 1'b0;
            digit_nib_q   <= 4'h0;
            dp_n_q        <= 1'b1;
            an_n_q        <= '1;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            run_q         <= 1'b1;
            act_val_q     <= act_val_d;
            act_dp_q      <= act_dp_d;
            pend_full_q   <= pend_full_d;
            digit_nib_q   <= digit_nib_d;
            dp_n_q        <= dp_n_d;
            an_n_q        <= an_n_d;
            frame_start_q <= frame_start_d;
            if (xfer) begin
                pend_val_q <= bus.ld_value;
                pend_dp_q  <= bus.ld_dp;
            end
        end
    end

    assign bus.ld_ready    = ld_ready;
    assign bus.digit_nib   = digit_nib_q;
    assign bus.dp_n        = dp_n_q;
    assign bus.an_n        = an_n_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed and random stimulus for seg7_scan_ctrl, every cycle checked against a
// model that derives slot, offset and frame boundaries from a running cycle count.
module tb_seg7_scan_ctrl;
    localparam int ND    = 8;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = DIV * ND;

    logic clk = 1'b0;
    logic rst;

    seg7_scan_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          c      = 0;
    logic [31:0] m_act, m_pend_val;
    logic [7:0]  m_dp, m_pend_dp;
    bit          m_pend, m_lz, last_xfer;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, c);
        end
    endtask

    // One clock cycle: check the outputs for cycle c, then advance the model.
    task automatic cycle();
        int         slot, off;
        bit         supp;
        logic [7:0] e_an;
        bit         e_rdy;
        @(negedge clk);
        slot  = (c / DIV) % ND;
        off   = c % DIV;
        supp  = m_lz && (slot != 0) && !m_dp[slot] && ((m_act >> (4*slot)) == 32'd0);
        e_an  = (off < BLANK || supp) ? 8'hFF : ~(8'h01 << slot);
        e_rdy = !m_pend;
        chk("digit_nib",   32'(bus.digit_nib),   32'(m_act[slot*4 +: 4]));
        chk("dp_n",        32'(bus.dp_n),        32'(!m_dp[slot]));
        chk("an_n",        32'(bus.an_n),        32'(e_an));
        chk("frame_start", 32'(bus.frame_start), 32'((c % FRAME) == 0));
        chk("ld_ready",    32'(bus.ld_ready),    32'(e_rdy));
        last_xfer = bus.ld_valid && e_rdy;
        @(posedge clk);
        if ((c % FRAME) == FRAME - 1 && m_pend) begin
            m_act  = m_pend_val;
            m_dp   = m_pend_dp;
            m_pend = 1'b0;
        end
        if (last_xfer) begin
            m_pend_val = bus.ld_value;
            m_pend_dp  = bus.ld_dp;
            m_pend     = 1'b1;
        end
        m_lz = bus.lz_en;
        c++;
        #1;
    endtask

    task automatic run(int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset(int n);
        bus.ld_valid = 1'b0;
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_an_n",        32'(bus.an_n),        32'hFF);
            chk("rst_dp_n",        32'(bus.dp_n),        32'd1);
            chk("rst_digit_nib",   32'(bus.digit_nib),   32'd0);
            chk("rst_ld_ready",    32'(bus.ld_ready),    32'd0);
            chk("rst_frame_start", 32'(bus.frame_start), 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("rel_ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("rel_an_n",     32'(bus.an_n),     32'hFF);
        m_act  = '0;
        m_dp   = '0;
        m_pend = 1'b0;
        c      = 0;
        @(posedge clk);
        m_lz = bus.lz_en;
        #1;
    endtask

    // Present a value and hold it until the model-predicted transfer happens.
    task automatic load(logic [31:0] v, logic [7:0] d);
        bus.ld_value = v;
        bus.ld_dp    = d;
        bus.ld_valid = 1'b1;
        for (int i = 0; i < 4 * FRAME; i++) begin
            cycle();
            if (last_xfer) break;
        end
        bus.ld_valid = 1'b0;
        bus.ld_value = $urandom;
        bus.ld_dp    = 8'($urandom);
    endtask

    initial begin
        logic [31:0] v;
        int          z;
        rst          = 1'b1;
        bus.ld_valid = 1'b0;
        bus.ld_value = '0;
        bus.ld_dp    = '0;
        bus.lz_en    = 1'b0;

        do_reset(3);
        run(FRAME + 5);

        // basic scan with one decimal point
        load(32'h12345678, 8'h04);
        run(2 * FRAME);

        // leading-zero suppression
        bus.lz_en = 1'b1;
        load(32'h00000A05, 8'h00);
        run(2 * FRAME);
        load(32'h00000000, 8'h00);
        run(2 * FRAME);
        load(32'h00000000, 8'h10);
        run(2 * FRAME);

        // back-to-back loads: second waits for the first commit
        bus.lz_en = 1'b0;
        load(32'hAAAA5555, 8'h81);
        load(32'h0F1E2D3C, 8'h42);
        run(3 * FRAME);

        // transfer landing exactly on the commit cycle
        while ((c % FRAME) != FRAME - 1) cycle();
        bus.ld_value = 32'hCAFEBABE;
        bus.ld_dp    = 8'h18;
        bus.ld_valid = 1'b1;
        cycle();
        bus.ld_valid = 1'b0;
        run(3 * FRAME);

        // random values with random leading-zero depth, dp and suppression mode
        for (int k = 0; k < 24; k++) begin
            v = $urandom;
            z = $urandom_range(0, 8);
            if (z == 8) v = 32'd0;
            else        v = v & (32'hFFFFFFFF >> (4 * z));
            bus.lz_en = 1'($urandom_range(0, 1));
            load(v, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
            run($urandom_range(1, 150));
        end

        // reset while a load is pending, mid-slot
        run(2 * FRAME + 2);
        while ((c % FRAME) != 10) cycle();
        load(32'h87654321, 8'hFF);
        run(3);
        do_reset(3);
        run(2 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode seven-segment digits sharing one `bin_to_7seg` decoder. It holds a multi-digit hex value and steps one digit per refresh slot: it presents that digit's nibble to the decoder, drives the decimal point, and enables one active-low anode. New display values arrive over a valid/ready handshake and take effect only at frame boundaries, so a frame never shows a mix of old and new digits. It also blanks all anodes at the start of each slot against ghosting, and can optionally suppress leading zeros.

## Interface
- `NUM_DIGITS`, 8: digits scanned, 1..8; digit 0 is least significant.
- `DIV`, 1000: clock cycles per digit slot, ≥2.
- `BLANK`, 16: anti-ghost blank cycles at the start of each slot, 0 ≤ BLANK < DIV.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ld_valid` in 1: load request.
- `ld_ready` out 1: controller can accept a load.
- `ld_value` in 4*NUM_DIGITS: hex digits; nibble i is `[4i+3:4i]`.
- `ld_dp` in NUM_DIGITS: decimal-point enable per digit, 1 = lit.
- `lz_en` in 1: leading-zero suppression enable; sampled every cycle.
- `digit_nib` out 4: nibble to the `bin_to_7seg` input.
- `dp_n` out 1: decimal point, active low.
- `an_n` out NUM_DIGITS: anode enables, active low, at most one low.
- `frame_start` out 1: one-cycle pulse in the first cycle of slot 0.

## Operation
**State**
- Slot counter `cnt`, range 0..DIV-1.
- Digit index `idx`, range 0..NUM_DIGITS-1.
- Active value and dp registers.
- Pending value and dp registers, plus a `pend_full` flag.

**Scan**
- `cnt` increments every cycle.
- At `cnt==DIV-1`: `cnt` returns to 0 and `idx` advances. From NUM_DIGITS-1 it wraps to 0.

**Load handshake**
- `ld_ready = !pend_full && !rst`.
- A transfer occurs when `ld_valid && ld_ready`. It captures `ld_value`/`ld_dp` into pending and sets `pend_full`.
- Holding `ld_valid` while `ld_ready` is low has no effect. The source must hold its data until a transfer occurs.

**Commit**
- Commit happens on the last cycle of the last slot (`cnt==DIV-1 && idx==NUM_DIGITS-1`) when `pend_full` was already set before that cycle.
- On commit, pending is copied to active and `pend_full` clears. `ld_ready` rises the following cycle.
- A transfer that lands in the commit cycle itself is not committed until the next frame boundary.

**Digit display**
- `digit_nib` is the active nibble `idx`.
- `dp_n` is `~active_dp[idx]`.

**Suppression** (when `lz_en`=1)
- Digit `idx` is suppressed if all of the following hold: `idx != 0`, active nibbles `idx..NUM_DIGITS-1` are all zero, and `active_dp[idx]`=0.
- A value of 0 therefore shows a single "0" on digit 0.

**Anodes**
- `an_n` is all ones when `cnt < BLANK` or the current digit is suppressed.
- Otherwise `an_n` has only bit `idx` low.
- `digit_nib`/`dp_n` stay valid during blanking.

**Reset** (synchronous, takes effect at the clock edge with `rst`=1)
- `cnt`, `idx` = 0.
- Active and pending value = 0; dp = 0; `pend_full` = 0.
- Outputs: `an_n` all ones, `digit_nib` = 0, `dp_n` = 1, `frame_start` = 0, `ld_ready` = 0 while `rst` is high.
- A mid-slot or mid-frame reset discards any pending load without committing it.

## Timing
- All outputs are registered, aligned with `cnt`/`idx` (a registered-output implementation keeps them in phase).
- The first cycle after `rst` deasserts is cycle 0 of slot 0, with `frame_start`=1.
- Slot i occupies cycles [i·DIV, (i+1)·DIV). The frame period is NUM_DIGITS·DIV cycles.
- Within a slot, `an_n` is high for BLANK cycles, then low on bit i for DIV−BLANK cycles.
- Load-to-display latency: a transfer in cycle t becomes visible in slot 0 of the first frame that starts after the first boundary strictly later than t. Maximum latency is 2 frames.
- `ld_ready` is low from the cycle after a transfer until the cycle after its commit.

## Test plan
Unless stated otherwise, the bench uses DIV=8, BLANK=2, NUM_DIGITS=8.
1. Reset: hold `rst` 3 cycles mid-slot.
   -> `an_n`=8'hFF, `dp_n`=1, `digit_nib`=0, `ld_ready`=0.
   -> After release: `frame_start`=1 on the first cycle, `ld_ready`=1.
2. Basic scan: load 32'h12345678 with `ld_dp`=8'h04, `lz_en`=0.
   -> After commit, slot k shows `digit_nib` = nibble k (8,7,6,5,4,3,2,1).
   -> `an_n` is FF for 2 cycles, then ~(1<<k) for 6 cycles.
   -> `dp_n`=0 only in slot 2.
3. Leading zeros: `lz_en`=1, value 32'h00000A05, dp 0.
   -> Slots 0, 1, 2 enable anodes (nibbles 5, 0, A).
   -> Slots 3..7 keep `an_n`=FF.
   -> Value 0: only slot 0 lights. Value 0 with `ld_dp`=8'h10: slots 0 and 4 light.
4. Handshake back-pressure: two loads back-to-back (A then B).
   -> A transfers; `ld_ready`=0 until the cycle after the next boundary.
   -> B then transfers and appears one frame after A.
   -> No frame mixes nibbles of A and B.
5. Commit-cycle race: with pending empty, assert `ld_valid` exactly on the commit cycle.
   -> The transfer occurs but the value appears only after the following boundary.
6. Reset during pending: transfer a load, assert `rst` before the boundary.
   -> After release, the display shows value 0 and `ld_ready`=1.
